// File: rtl/charlieplex_keyscan.sv
// Charlieplexed key-matrix scanner: drives one pin low per row, samples the
// remaining pins through a 2-flop synchronizer, and debounces a key bitmap.
module charlieplex_keyscan #(
  parameter int unsigned PINCOUNT       = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [PINCOUNT-1:0]                pin_in,
  output logic [PINCOUNT-1:0]                out_en,
  output logic [PINCOUNT-1:0]                out_value,
  output logic [PINCOUNT*(PINCOUNT-1)-1:0]   keys,
  output logic                               scan_done,
  output logic                               changed
);

  localparam int unsigned KEYCOUNT = PINCOUNT * (PINCOUNT - 1);
  localparam int unsigned KEY_W    = (KEYCOUNT > 1) ? $clog2(KEYCOUNT) : 1;
  localparam int unsigned ROW_W    = (PINCOUNT > 1) ? $clog2(PINCOUNT) : 1;
  localparam int unsigned SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } state_t;

  // Same key numbering as the LED driver: column x senses, row y drives.
  function automatic int unsigned key_index(input int unsigned x, input int unsigned y);
    return (x > y) ? (PINCOUNT - 1) * x + y : (PINCOUNT - 1) * x + y - 1;
  endfunction

  state_t                            state, state_d;
  logic [ROW_W-1:0]                  row, row_d;
  logic [SET_W-1:0]                  settle, settle_d;
  logic [KEYCOUNT-1:0]               raw, raw_d;
  logic [KEYCOUNT-1:0]               keys_d, toggle;
  logic [KEYCOUNT-1:0][CNT_W-1:0]    cnt, cnt_d;
  logic                              scan_done_d, changed_d;
  logic [PINCOUNT-1:0]               out_en_d;
  logic [PINCOUNT-1:0]               pin_meta, pin_sync;

  // Driven pins are only ever pulled to ground.
  assign out_value = '0;

  // Next-state, sampling and debounce logic.
  always_comb begin
    state_d     = state;
    row_d       = row;
    settle_d    = settle;
    raw_d       = raw;
    keys_d      = keys;
    cnt_d       = cnt;
    scan_done_d = 1'b0;
    changed_d   = 1'b0;
    toggle      = '0;
    out_en_d    = '0;

    case (state)
      IDLE: begin
        if (enable) state_d = DRIVE;
      end
      DRIVE: begin
        if (settle == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d  = SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle + 1'b1;
        end
      end
      SAMPLE: begin
        for (int unsigned x = 0; x < PINCOUNT; x++) begin
          if (ROW_W'(x) != row) raw_d[KEY_W'(key_index(x, 32'(row)))] = ~pin_sync[x];
        end
        state_d = DRIVE;
        if (row == ROW_W'(PINCOUNT - 1)) begin
          row_d = '0;
          // Counter tracks consecutive scans disagreeing with the reported state.
          for (int unsigned k = 0; k < KEYCOUNT; k++) begin
            if (raw_d[k] == keys[k]) begin
              cnt_d[k] = '0;
            end else if (cnt[k] >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
              toggle[k] = 1'b1;
              cnt_d[k]  = '0;
            end else begin
              cnt_d[k] = cnt[k] + 1'b1;
            end
          end
          keys_d      = keys ^ toggle;
          scan_done_d = 1'b1;
          changed_d   = |toggle;
        end else begin
          row_d = row + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort drops the partial scan but keeps keys and debounce history.
    if (!enable) begin
      state_d     = IDLE;
      row_d       = '0;
      settle_d    = '0;
      raw_d       = '0;
      keys_d      = keys;
      cnt_d       = cnt;
      scan_done_d = 1'b0;
      changed_d   = 1'b0;
    end

    if (state_d != IDLE) out_en_d[row_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      settle    <= '0;
      raw       <= '0;
      keys      <= '0;
      cnt       <= '0;
      scan_done <= 1'b0;
      changed   <= 1'b0;
      out_en    <= '0;
      pin_meta  <= '1;
      pin_sync  <= '1;
    end else begin
      state     <= state_d;
      row       <= row_d;
      settle    <= settle_d;
      raw       <= raw_d;
      keys      <= keys_d;
      cnt       <= cnt_d;
      scan_done <= scan_done_d;
      changed   <= changed_d;
      out_en    <= out_en_d;
      pin_meta  <= pin_in;
      pin_sync  <= pin_meta;
    end
  end

endmodule

// File: tb/tb_charlieplex_keyscan.sv
// Directed bench for charlieplex_keyscan with a diode-matrix pin model.
module tb_charlieplex_keyscan;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  pin_in;
  logic [3:0]  out_en;
  logic [3:0]  out_value;
  logic [11:0] keys;
  logic        scan_done;
  logic        changed;

  logic [3:0][3:0] press;  // press[x][y]: sense column x, drive row y

  int checks = 0;
  int failures = 0;
  int changed_pulses = 0;
  int orphan_changed = 0;
  int bad_value = 0;

  logic [11:0] k_obs;
  logic        c_obs;

  charlieplex_keyscan #(
    .PINCOUNT(4),
    .SETTLE_CYCLES(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .pin_in(pin_in),
    .out_en(out_en),
    .out_value(out_value),
    .keys(keys),
    .scan_done(scan_done),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // A driven pin reads low; a pressed key pulls its column low while its row is driven.
  always_comb begin
    pin_in = '1;
    for (int x = 0; x < 4; x++) begin
      if (out_en[x]) pin_in[x] = 1'b0;
      for (int y = 0; y < 4; y++) begin
        if (press[x][y] && out_en[y]) pin_in[x] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (changed) changed_pulses++;
      if (changed && !scan_done) orphan_changed++;
      if (out_value != 4'b0000) bad_value++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_scan(output logic [11:0] k, output logic ch);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 25);
    if (!scan_done) check("scan_timeout", 32'(scan_done), 32'd1);
    k  = keys;
    ch = changed;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    press  = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_out_en", 32'(out_en), 32'h0);
      check("rst_keys", 32'(keys), 32'h0);
    end
    check("rst_scan_done", 32'(scan_done), 32'h0);
    check("rst_changed", 32'(changed), 32'h0);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("release_out_en", 32'(out_en), 32'h0);
    @(negedge clk);
    check("first_drive", 32'(out_en), 32'h1);

    // Idle scan: 5 cycles per row, scan_done 20 cycles after first drive.
    for (int i = 0; i < 20; i++) begin
      check("scan_out_en", 32'(out_en), 32'(1 << (i / 5)));
      check("scan_done_early", 32'(scan_done), 32'h0);
      @(negedge clk);
    end
    check("scan_done_20", 32'(scan_done), 32'h1);
    check("idle_keys", 32'(keys), 32'h0);
    check("idle_changed", 32'(changed), 32'h0);
    check("wrap_out_en", 32'(out_en), 32'h1);

    // Key 5 (x=1, y=3): press then release, three scans each.
    press[1][3] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_scan(k_obs, c_obs);
      check("press_keys", 32'(k_obs), (s == 2) ? 32'h020 : 32'h000);
      check("press_changed", 32'(c_obs), (s == 2) ? 32'h1 : 32'h0);
    end
    press[1][3] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_scan(k_obs, c_obs);
      check("release_keys", 32'(k_obs), (s == 2) ? 32'h000 : 32'h020);
      check("release_changed", 32'(c_obs), (s == 2) ? 32'h1 : 32'h0);
    end

    // Bounce: held 2, released 1, held 2, released 2 -- never reaches 3.
    for (int s = 0; s < 7; s++) begin
      press[1][3] = (s < 2 || s == 3 || s == 4);
      wait_scan(k_obs, c_obs);
      check("bounce_keys", 32'(k_obs), 32'h0);
      check("bounce_changed", 32'(c_obs), 32'h0);
    end
    press[1][3] = 1'b0;

    // Row 1: keys 0 (x=0) and 10 (x=3) together.
    press[0][1] = 1'b1;
    press[3][1] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_scan(k_obs, c_obs);
      check("multi_keys", 32'(k_obs), (s == 2) ? 32'h401 : 32'h000);
      check("multi_changed", 32'(c_obs), (s == 2) ? 32'h1 : 32'h0);
    end

    // Enable dropped during row 2, restored 10 cycles later.
    repeat (12) @(negedge clk);
    check("pre_drop_row2", 32'(out_en), 32'h4);
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("off_out_en", 32'(out_en), 32'h0);
      check("off_scan_done", 32'(scan_done), 32'h0);
      check("off_keys", 32'(keys), 32'h401);
      @(negedge clk);
    end
    enable = 1'b1;
    @(negedge clk);
    check("restart_row0", 32'(out_en), 32'h1);
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      check("restart_no_done", 32'(scan_done), 32'h0);
    end
    @(negedge clk);
    check("restart_done", 32'(scan_done), 32'h1);
    check("restart_keys", 32'(keys), 32'h401);
    check("restart_changed", 32'(changed), 32'h0);

    check("changed_pulses", 32'(changed_pulses), 32'd3);
    check("changed_without_done", 32'(orphan_changed), 32'd0);
    check("out_value_nonzero", 32'(bad_value), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/charlieplex_keyscan.md
# charlieplex_keyscan

Scans a charlieplexed key matrix of PINCOUNT*(PINCOUNT-1) keys over PINCOUNT tristateable pins and produces a debounced key bitmap. It is the input-side counterpart to the charlieplexed LED driver. It uses the same pin wiring, the same NxN grid and the same key-index mapping, so one board layout serves both. It sits between the FPGA's tristate I/O cells (with pull-ups enabled) and the application logic.

## Interface
- PINCOUNT, 4, number of matrix pins; KEYCOUNT = PINCOUNT*(PINCOUNT-1) (localparam).
- SETTLE_CYCLES, 4, cycles a row is driven before it is sampled; must be ≥3 (covers the 2-flop synchronizer).
- DEBOUNCE_SCANS, 3, consecutive full scans a raw key state must disagree with `keys` before `keys` changes; must be ≥1.
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  scanning enabled; when low, all pins are tristated and `keys` is held.
- pin_in  input  PINCOUNT  raw pin levels from I/O cells (pulled up, asynchronous).
- out_en  output  PINCOUNT  drive enable per pin (1 = driven, 0 = tristate).
- out_value  output  PINCOUNT  drive value per pin; constant 0 (driven pins are pulled to GND).
- keys  output  KEYCOUNT  debounced state, 1 = pressed.
- scan_done  output  1  one-cycle pulse when `keys` has been updated after a full scan.
- changed  output  1  one-cycle pulse, coincident with `scan_done`, if any `keys` bit changed in that update.

## Operation
- Key at grid column x (sense pin) and row y (drive pin), x≠y, has index (PINCOUNT-1)*x+y if x>y, else (PINCOUNT-1)*x+y-1. Each key has a series diode, so a pressed key pulls sense pin x low while row y is driven low.
- pin_in passes through a 2-flop synchronizer (pin_sync) before use.
- FSM states:
  - IDLE: out_en=0, row=0, settle count=0.
  - DRIVE: out_en=one-hot(row); settle counter runs 0..SETTLE_CYCLES-1.
  - SAMPLE: still driving; raw[idx(x,row)] = ~pin_sync[x] for all x≠row; pin_sync[row] is ignored.
- Transitions:
  - IDLE→DRIVE when enable=1.
  - DRIVE→SAMPLE when the settle count reaches SETTLE_CYCLES-1.
  - SAMPLE→DRIVE with row+1, or with row=0 after row PINCOUNT-1. The wrap also performs the debounce update.
  - Any state→IDLE when enable=0. Partial raw data is discarded and `keys` and the debounce counters keep their values.
- Debounce update, per key k, at scan end:
  - If raw[k]==keys[k], clear cnt[k].
  - Otherwise cnt[k]+1. When it reaches DEBOUNCE_SCANS, toggle keys[k] and clear cnt[k].
  - cnt[k] is $clog2(DEBOUNCE_SCANS+1) bits wide and saturates, never wraps.
- Multiple simultaneous keys are reported independently. Ghost-free operation relies on the diodes.

## Timing
- Reset values: out_en=0, out_value=0, keys=0, scan_done=0, changed=0, all counters 0, state IDLE, synchronizer flops 1.
- Row phase lasts exactly SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE, then 1 in SAMPLE. Rows follow back-to-back with no gap.
- Full scan lasts PINCOUNT*(SETTLE_CYCLES+1) cycles.
- With enable high from reset release:
  - First drive (out_en=0...01) appears on the 2nd edge after rst deasserts (IDLE→DRIVE).
  - scan_done pulses every scan period thereafter.
- keys, scan_done and changed update on the edge that ends SAMPLE of row PINCOUNT-1. This is the same edge that starts DRIVE of row 0.
- Press-to-`keys` latency is DEBOUNCE_SCANS scans from the first scan sampling the pressed level. Release latency is the same.
- enable low: out_en=0 on the next edge. scan_done is not pulsed for an aborted scan.
- rst mid-scan overrides everything, including an enable edge in the same cycle.

## Test plan
- Reset with pin_in=all 1 and enable=1 held: out_en=0 and keys=0 while rst is high; first out_en=0001 on the 2nd edge after release.
- PINCOUNT=4, SETTLE_CYCLES=4, no keys pressed: out_en steps 0001→0010→0100→1000, 5 cycles each; scan_done every 20 cycles; keys=0; changed never asserts; out_value always 0000.
- Key 5 (x=1,y=3), model pulls pin_in[1]=0 whenever out_en[3]=1, DEBOUNCE_SCANS=3: keys=0x020 after the 3rd scan_done with changed=1 once. On release, keys=0 after 3 further scans with changed=1 once.
- Bounce: key 5 held for 2 scans, released for 1, held for 2, then released: keys stays 0 and changed never pulses.
- Row y=1 keys 0 (x=0) and 10 (x=3) pressed together: both bits set in the same update (keys=0x401); pin_in[1] low during row 1 is ignored.
- enable dropped during row 2, restored 10 cycles later: out_en=0 on the next edge; keys retained; no scan_done; scanning restarts at row 0, and the next scan_done comes a full 20-cycle scan after the first restored drive cycle.
